// File: rtl/patch_dump_pkg.sv
// Shared types and constants for the SysEx patch dump sequencer.
// Imported by the address generator and the top-level sequencer.
package patch_dump_pkg;

  typedef enum logic [3:0] {
    IDLE, HDR0, HDR1, RD, WT, CAP, SEND, CSUM, EOX
  } state_e;

  // Encoding doubles as the bit position of the section in the one-hot select.
  typedef enum logic [1:0] {
    SEC_COM = 2'd0,
    SEC_OSC = 2'd1,
    SEC_M1  = 2'd2,
    SEC_M2  = 2'd3
  } section_e;

  localparam logic [7:0] SYX_START = 8'hF0;
  localparam logic [7:0] SYX_END   = 8'hF7;
  localparam int unsigned OSC_REGS = 6;

  function automatic logic [3:0] osc_offset(input logic [2:0] k);
    case (k)
      3'd0:    osc_offset = 4'd2;
      3'd1:    osc_offset = 4'd3;
      3'd2:    osc_offset = 4'd4;
      3'd3:    osc_offset = 4'd7;
      3'd4:    osc_offset = 4'd10;
      3'd5:    osc_offset = 4'd11;
      default: osc_offset = 4'd2;
    endcase
  endfunction

  function automatic int unsigned dump_len(input int unsigned v_osc);
    return 32'd21 + 32'd38 * v_osc;
  endfunction

endpackage

// File: rtl/patch_dump_sequencer_addr_gen.sv
// Section/index counters that walk every dumped register address.
// The FSM clears it at the start of a dump and steps it once per byte.
module dump_addr_gen
  import patch_dump_pkg::*;
#(
  parameter int unsigned V_OSC = 4
) (
  input  logic       data_clk,
  input  logic       reset_data_N,
  input  logic       clear_i,
  input  logic       step_i,
  output logic [6:0] adr_o,
  output logic [3:0] sel_o,
  output logic       last_o
);

  localparam logic [6:0] COM_LAST = 7'd16;
  localparam logic [6:0] MAT_LAST = 7'(16 * V_OSC - 1);
  localparam logic [2:0] OSC_LAST = 3'(V_OSC - 1);
  localparam logic [2:0] OFS_LAST = 3'(OSC_REGS - 1);

  section_e   sec_q, sec_d;
  logic [6:0] idx_q, idx_d;
  logic [2:0] osc_q, osc_d;
  logic [2:0] ofs_q, ofs_d;

  // Counter registers.
  always_ff @(posedge data_clk or negedge reset_data_N) begin
    if (!reset_data_N) begin
      sec_q <= SEC_COM;
      idx_q <= 7'd0;
      osc_q <= 3'd0;
      ofs_q <= 3'd0;
    end else begin
      sec_q <= sec_d;
      idx_q <= idx_d;
      osc_q <= osc_d;
      ofs_q <= ofs_d;
    end
  end

  // Advance through COM, then each oscillator's offsets, then both matrices.
  always_comb begin
    sec_d = sec_q;
    idx_d = idx_q;
    osc_d = osc_q;
    ofs_d = ofs_q;
    if (clear_i) begin
      sec_d = SEC_COM;
      idx_d = 7'd0;
      osc_d = 3'd0;
      ofs_d = 3'd0;
    end else if (step_i) begin
      case (sec_q)
        SEC_COM: begin
          if (idx_q == COM_LAST) begin
            sec_d = SEC_OSC;
            idx_d = 7'd0;
          end else begin
            idx_d = idx_q + 7'd1;
          end
        end
        SEC_OSC: begin
          if (ofs_q == OFS_LAST) begin
            ofs_d = 3'd0;
            if (osc_q == OSC_LAST) begin
              osc_d = 3'd0;
              sec_d = SEC_M1;
            end else begin
              osc_d = osc_q + 3'd1;
            end
          end else begin
            ofs_d = ofs_q + 3'd1;
          end
        end
        SEC_M1: begin
          if (idx_q == MAT_LAST) begin
            sec_d = SEC_M2;
            idx_d = 7'd0;
          end else begin
            idx_d = idx_q + 7'd1;
          end
        end
        SEC_M2: begin
          if (idx_q == MAT_LAST) begin
            idx_d = idx_q;
          end else begin
            idx_d = idx_q + 7'd1;
          end
        end
        default: begin
          sec_d = SEC_COM;
          idx_d = 7'd0;
        end
      endcase
    end else begin
      sec_d = sec_q;
    end
  end

  // Matrix index is already 16*i + j; an oscillator's base is osc*16.
  always_comb begin
    case (sec_q)
      SEC_COM: adr_o = (idx_q == 7'd0) ? 7'd1 : (idx_q + 7'd15);
      SEC_OSC: adr_o = {osc_q, osc_offset(ofs_q)};
      SEC_M1:  adr_o = idx_q;
      SEC_M2:  adr_o = idx_q;
      default: adr_o = 7'd0;
    endcase
  end

  assign sel_o  = 4'b0001 << sec_q;
  assign last_o = (sec_q == SEC_M2) && (idx_q == MAT_LAST);

endmodule

// File: rtl/patch_dump_sequencer.sv
// Reads the mixer register bank over the shared bus and frames it as a SysEx
// patch dump; decoder accesses pass through to the bank whenever no dump runs.
module patch_dump_sequencer
  import patch_dump_pkg::*;
#(
  parameter int unsigned V_OSC    = 4,
  parameter logic [7:0]  SYSEX_ID = 8'h7D
) (
  input  logic       data_clk,
  input  logic       reset_data_N,
  input  logic       dump_req,
  output logic       dump_busy,
  input  logic [6:0] dec_adr,
  input  logic       dec_write_n,
  input  logic       dec_osc_sel,
  input  logic       dec_com_sel,
  input  logic       dec_m1_sel,
  input  logic       dec_m2_sel,
  output logic       dec_stall,
  output logic [6:0] bank_adr,
  output logic       bank_write_n,
  output logic       bank_read,
  output logic       bank_osc_sel,
  output logic       bank_com_sel,
  output logic       bank_m1_sel,
  output logic       bank_m2_sel,
  output logic       patch_send,
  input  logic [7:0] bank_data,
  output logic [7:0] tx_data,
  output logic       tx_valid,
  input  logic       tx_ready
);

  state_e     state_q, state_d;
  logic [7:0] tx_data_q, tx_data_d;
  logic       tx_valid_q, tx_valid_d;
  logic [6:0] csum_q, csum_d;
  logic       gen_clear_s, gen_step_s, gen_last_s;
  logic       sel_en_s;
  logic [6:0] gen_adr_s;
  logic [3:0] gen_sel_s;

  dump_addr_gen #(.V_OSC(V_OSC)) u_addr_gen (
    .data_clk    (data_clk),
    .reset_data_N(reset_data_N),
    .clear_i     (gen_clear_s),
    .step_i      (gen_step_s),
    .adr_o       (gen_adr_s),
    .sel_o       (gen_sel_s),
    .last_o      (gen_last_s)
  );

  // State, output byte and checksum registers.
  always_ff @(posedge data_clk or negedge reset_data_N) begin
    if (!reset_data_N) begin
      state_q    <= IDLE;
      tx_data_q  <= 8'h00;
      tx_valid_q <= 1'b0;
      csum_q     <= 7'd0;
    end else begin
      state_q    <= state_d;
      tx_data_q  <= tx_data_d;
      tx_valid_q <= tx_valid_d;
      csum_q     <= csum_d;
    end
  end

  // Next state, byte loading and bank read strobes.
  always_comb begin
    state_d     = state_q;
    tx_data_d   = tx_data_q;
    tx_valid_d  = tx_valid_q;
    csum_d      = csum_q;
    gen_clear_s = 1'b0;
    gen_step_s  = 1'b0;
    bank_read   = 1'b0;
    patch_send  = 1'b0;
    sel_en_s    = 1'b0;
    case (state_q)
      IDLE: begin
        if (dump_req) begin
          state_d    = HDR0;
          tx_data_d  = SYX_START;
          tx_valid_d = 1'b1;
        end else begin
          state_d = IDLE;
        end
      end
      HDR0: begin
        csum_d      = 7'd0;
        gen_clear_s = 1'b1;
        if (tx_ready) begin
          state_d   = HDR1;
          tx_data_d = SYSEX_ID;
        end else begin
          state_d = HDR0;
        end
      end
      HDR1: begin
        if (tx_ready) begin
          state_d    = RD;
          tx_valid_d = 1'b0;
        end else begin
          state_d = HDR1;
        end
      end
      RD: begin
        bank_read  = 1'b1;
        patch_send = 1'b1;
        sel_en_s   = 1'b1;
        state_d    = WT;
      end
      WT: begin
        patch_send = 1'b1;
        sel_en_s   = 1'b1;
        state_d    = CAP;
      end
      CAP: begin
        patch_send = 1'b1;
        sel_en_s   = 1'b1;
        tx_data_d  = bank_data & 8'h7F;
        tx_valid_d = 1'b1;
        csum_d     = csum_q + tx_data_d[6:0];
        state_d    = SEND;
      end
      SEND: begin
        if (tx_ready) begin
          if (gen_last_s) begin
            state_d   = CSUM;
            tx_data_d = {1'b0, 7'd0 - csum_q};
          end else begin
            state_d    = RD;
            tx_valid_d = 1'b0;
            gen_step_s = 1'b1;
          end
        end else begin
          state_d = SEND;
        end
      end
      CSUM: begin
        if (tx_ready) begin
          state_d   = EOX;
          tx_data_d = SYX_END;
        end else begin
          state_d = CSUM;
        end
      end
      EOX: begin
        if (tx_ready) begin
          state_d    = IDLE;
          tx_valid_d = 1'b0;
        end else begin
          state_d = EOX;
        end
      end
      default: begin
        state_d    = IDLE;
        tx_valid_d = 1'b0;
      end
    endcase
  end

  // Bank bus mux: decoder in IDLE, address generator during a dump.
  always_comb begin
    bank_adr     = 7'd0;
    bank_write_n = 1'b1;
    bank_com_sel = 1'b0;
    bank_osc_sel = 1'b0;
    bank_m1_sel  = 1'b0;
    bank_m2_sel  = 1'b0;
    if (state_q == IDLE) begin
      if (reset_data_N) begin
        bank_adr     = dec_adr;
        bank_write_n = dec_write_n;
        bank_com_sel = dec_com_sel;
        bank_osc_sel = dec_osc_sel;
        bank_m1_sel  = dec_m1_sel;
        bank_m2_sel  = dec_m2_sel;
      end else begin
        bank_adr = 7'd0;
      end
    end else begin
      bank_adr     = gen_adr_s;
      bank_com_sel = sel_en_s & gen_sel_s[0];
      bank_osc_sel = sel_en_s & gen_sel_s[1];
      bank_m1_sel  = sel_en_s & gen_sel_s[2];
      bank_m2_sel  = sel_en_s & gen_sel_s[3];
    end
  end

  assign dump_busy = (state_q != IDLE);
  assign dec_stall = (state_q != IDLE);
  assign tx_data   = tx_data_q;
  assign tx_valid  = tx_valid_q;

endmodule
